// File: rtl/user_input_pkg.sv
// Shared types and constants for the user input arbiter.
package user_input_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } uia_state_t;

    localparam int UIA_N_DEFAULT = 4;

    function automatic int id_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Single-channel rising-edge detector. The history flop resets to 1 so that a
// key held through reset is not reported until it is released and pressed again.
module key_edge_detect (
    input  logic Clock,
    input  logic Reset,
    input  logic key,
    output logic rise
);

    logic prev;

    // Track the previous key level
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) prev <= 1'b1;
        else       prev <= key;
    end

    assign rise = key & ~prev;

endmodule

// File: rtl/user_input_arbiter.sv
// Round-robin serialiser of key press events onto a single valid/ready port.
// Optional build macro UIA_LOCKOUT_EN adds a per-channel post-accept lockout
// window of LOCKOUT_CYCLES clocks during which presses on that channel are ignored.
module user_input_arbiter
    import user_input_pkg::*;
#(
    parameter int N              = UIA_N_DEFAULT,
    parameter int LOCKOUT_CYCLES = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [N-1:0]         key_in,
    output logic                 evt_valid,
    output logic [id_w(N)-1:0]   evt_id,
    input  logic                 evt_ready,
    output logic [N-1:0]         pending,
    output logic                 overflow
);

    localparam int          ID_W = id_w(N);
    localparam int unsigned NU   = N;

    uia_state_t      state, state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] pick;
    logic            pick_ok;
    int unsigned     scan_idx;
    logic            accept;
    logic [N-1:0]    acc_vec;
    logic [N-1:0]    rise;
    logic [N-1:0]    rise_eff;

    if (N < 2 || N > 16 || LOCKOUT_CYCLES < 1) begin : g_cfg_check
        $error("user_input_arbiter: unsupported parameter set");
    end

    for (genvar g = 0; g < N; g++) begin : g_edge
        key_edge_detect u_ked (
            .Clock (Clock),
            .Reset (Reset),
            .key   (key_in[g]),
            .rise  (rise[g])
        );
    end

`ifdef UIA_LOCKOUT_EN
    localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);

    logic [LK_W-1:0] lock_cnt [N];

    // Reload a channel's lockout window on accept, then count it down to zero
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NU; i++) lock_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NU; i++) begin
                if (acc_vec[i])             lock_cnt[i] <= LK_W'(LOCKOUT_CYCLES);
                else if (lock_cnt[i] != '0) lock_cnt[i] <= lock_cnt[i] - LK_W'(1);
            end
        end
    end

    // Presses inside the lockout window are ignored entirely
    always_comb begin
        rise_eff = '0;
        for (int unsigned i = 0; i < NU; i++) rise_eff[i] = rise[i] & (lock_cnt[i] == '0);
    end
`else
    // Every detected press is eligible
    always_comb begin
        rise_eff = rise;
    end
`endif

    // Round-robin pick: first pending channel at or after rr_ptr, wrapping
    always_comb begin
        pick     = '0;
        pick_ok  = 1'b0;
        scan_idx = 0;
        for (int unsigned k = 0; k < NU; k++) begin
            scan_idx = (32'(rr_ptr) + k) % NU;
            if (!pick_ok && pending[ID_W'(scan_idx)]) begin
                pick_ok = 1'b1;
                pick    = ID_W'(scan_idx);
            end
        end
    end

    // FSM state register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_ok)   state_nxt = OFFER;
            OFFER:   if (evt_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: offer flag and one-hot accept vector
    always_comb begin
        evt_valid = (state == OFFER);
        accept    = evt_valid & evt_ready;
        acc_vec   = '0;
        if (accept) acc_vec[evt_id] = 1'b1;
    end

    // Pending bits, overflow pulse, offered id and round-robin pointer
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pending  <= '0;
            overflow <= 1'b0;
            evt_id   <= '0;
            rr_ptr   <= '0;
        end else begin
            // A press coinciding with the accept of its own channel re-arms the bit;
            // a press on a still-pending channel is dropped and flagged.
            overflow <= |(rise_eff & pending & ~acc_vec);
            pending  <= (pending & ~acc_vec) | rise_eff;
            if (state == IDLE && pick_ok) evt_id <= pick;
            if (accept) rr_ptr <= (evt_id == ID_W'(N - 1)) ? '0 : evt_id + ID_W'(1);
        end
    end

endmodule
